regfile_wb_arbiter: RTL and testbench

//   Writer-side front end for the 32x32 register file write port (RDaddr/RDdata/RegWrite).

---
 rtl/regfile_wb_arbiter_if.sv | 34 +++
 rtl/regfile_wb_arbiter.sv | 130 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of the writeback arbiter's pipeline-facing and register-file-facing signals.
// master: pipeline / producers side, slave: the arbiter itself.
interface regfile_wb_arbiter_if;
  logic        alu_we_i;
  logic [4:0]  alu_rd_i;
  logic [31:0] alu_data_i;
  logic        lsu_valid_i;
  logic        lsu_ready_o;
  logic [4:0]  lsu_rd_i;
  logic [31:0] lsu_data_i;
  logic        pend_set_i;
  logic [4:0]  pend_rd_i;
  logic [31:0] busy_o;
  logic        stall_o;
  logic [4:0]  RDaddr_o;
  logic [31:0] RDdata_o;
  logic        RegWrite_o;

  modport master (
    output alu_we_i, alu_rd_i, alu_data_i,
    output lsu_valid_i, lsu_rd_i, lsu_data_i,
    output pend_set_i, pend_rd_i,
    input  lsu_ready_o, busy_o, stall_o,
    input  RDaddr_o, RDdata_o, RegWrite_o
  );

  modport slave (
    input  alu_we_i, alu_rd_i, alu_data_i,
    input  lsu_valid_i, lsu_rd_i, lsu_data_i,
    input  pend_set_i, pend_rd_i,
    output lsu_ready_o, busy_o, stall_o,
    output RDaddr_o, RDdata_o, RegWrite_o
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU writebacks and FIFO-buffered long-latency results onto one register file write port,
// with a pending-write scoreboard. Optional WB_BYPASS_EN lets an idle slot take an LSU result directly.
module regfile_wb_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  wb
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [AW:0]   PTR_ONE = 1;
  localparam logic [SW-1:0] CNT_ONE = 1;
  localparam logic [SW-1:0] CNT_MAX = SW'(STARVE_MAX);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [SW-1:0] starve_cnt;
  logic [31:0]   busy_q;
  logic          wb_we_p1;
  logic [4:0]    wb_addr_p1;
  logic [31:0]   wb_data_p1;

  logic          empty, full, alu_take, pop, bypass, push, retire;
  entry_t        head;
  logic [4:0]    ret_rd;
  logic [31:0]   ret_data;
  logic [31:0]   clr_vec, set_vec, busy_live;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  assign alu_take = wb.alu_we_i && (wb.alu_rd_i != 5'd0);
  assign pop      = !alu_take && !empty;

`ifdef WB_BYPASS_EN
  assign bypass = !alu_take && empty && wb.lsu_valid_i;
`else
  assign bypass = 1'b0;
`endif

  // Ready comes from registered occupancy only; an empty FIFO is never full, so bypass is covered too.
  assign push   = wb.lsu_valid_i && !full && !bypass;
  assign retire = pop || bypass;

  always_comb begin
    ret_rd   = head.rd;
    ret_data = head.data;
    if (bypass) begin
      ret_rd   = wb.lsu_rd_i;
      ret_data = wb.lsu_data_i;
    end
  end

  always_comb begin
    clr_vec = 32'd0;
    set_vec = 32'd0;
    if (retire)
      clr_vec = 32'd1 << ret_rd;
    if (wb.pend_set_i)
      set_vec = (32'd1 << wb.pend_rd_i) & 32'hFFFF_FFFE;
  end

  assign busy_live = busy_q & ~clr_vec;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= '{rd: wb.lsu_rd_i, data: wb.lsu_data_i};
  end

  // Stage p1: output registers, FIFO pointers, starvation counter and scoreboard
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      starve_cnt <= '0;
      busy_q     <= 32'd0;
      wb_we_p1   <= 1'b0;
      wb_addr_p1 <= 5'd0;
      wb_data_p1 <= 32'd0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;

      if (pop)
        starve_cnt <= '0;
      else if (!empty && starve_cnt != CNT_MAX)
        starve_cnt <= starve_cnt + CNT_ONE;

      // Set wins over clear when both hit the same register on one edge.
      busy_q <= busy_live | set_vec;

      if (alu_take) begin
        wb_we_p1   <= 1'b1;
        wb_addr_p1 <= wb.alu_rd_i;
        wb_data_p1 <= wb.alu_data_i;
      end else if (retire && ret_rd != 5'd0) begin
        wb_we_p1   <= 1'b1;
        wb_addr_p1 <= ret_rd;
        wb_data_p1 <= ret_data;
      end else begin
        wb_we_p1   <= 1'b0;
      end
    end
  end

  assign wb.lsu_ready_o = !full;
  assign wb.busy_o      = busy_q;
  assign wb.stall_o     = (starve_cnt == CNT_MAX);
  assign wb.RegWrite_o  = wb_we_p1;
  assign wb.RDaddr_o    = wb_addr_p1;
  assign wb.RDdata_o    = wb_data_p1;

  pend_not_busy: assert property (@(posedge clk) disable iff (rst)
    (wb.pend_set_i && wb.pend_rd_i != 5'd0) |-> !busy_live[wb.pend_rd_i]);

  alu_not_busy: assert property (@(posedge clk) disable iff (rst)
    alu_take |-> !busy_q[wb.alu_rd_i]);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a queue-based reference model predicts writes and
// per-cycle status; a negedge monitor compares them against the DUT.
module tb_regfile_wb_arbiter;
  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if wb();

  regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb)
  );

  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int          cyc;
    logic [31:0] busy;
    logic        ready;
    logic        stall;
    bit          chk_bus;
  } st_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  wr_t exp_wr[$];
  st_t exp_st[$];

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  ent_t        m_q[$];
  logic [31:0] m_busy = 32'd0;
  int          m_starve = 0;
  logic [4:0]  launched[$];
  bit          have_item = 0;
  ent_t        item;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
  endtask

  always @(negedge clk) begin
    wr_t e;
    st_t s;
    if (wb.RegWrite_o === 1'b1) begin
      if (exp_wr.size() == 0) begin
        chk("unexpected_write", {31'd0, wb.RegWrite_o}, 32'd0);
      end else begin
        e = exp_wr.pop_front();
        chk("write_cycle", cyc, e.cyc);
        chk("write_addr", {27'd0, wb.RDaddr_o}, {27'd0, e.rd});
        chk("write_data", wb.RDdata_o, e.data);
      end
    end else if (exp_wr.size() > 0 && exp_wr[0].cyc <= cyc) begin
      e = exp_wr.pop_front();
      chk("missing_write", {31'd0, wb.RegWrite_o}, 32'd1);
    end
    while (exp_st.size() > 0 && exp_st[0].cyc < cyc) void'(exp_st.pop_front());
    if (exp_st.size() > 0 && exp_st[0].cyc == cyc) begin
      s = exp_st.pop_front();
      chk("busy", wb.busy_o, s.busy);
      chk("lsu_ready", {31'd0, wb.lsu_ready_o}, {31'd0, s.ready});
      chk("stall", {31'd0, wb.stall_o}, {31'd0, s.stall});
      if (s.chk_bus) begin
        chk("reset_regwrite", {31'd0, wb.RegWrite_o}, 32'd0);
        chk("reset_rdaddr", {27'd0, wb.RDaddr_o}, 32'd0);
        chk("reset_rddata", wb.RDdata_o, 32'd0);
      end
    end
  end

  task automatic drive_idle();
    wb.alu_we_i = 0; wb.alu_rd_i = 0; wb.alu_data_i = 0;
    wb.lsu_valid_i = 0; wb.lsu_rd_i = 0; wb.lsu_data_i = 0;
    wb.pend_set_i = 0; wb.pend_rd_i = 0;
  endtask

  // One cycle of stimulus; the model applies the arbitration rules to predict the next cycle.
  task automatic step(input bit aw, input logic [4:0] ard, input logic [31:0] adat,
                      input bit lv, input logic [4:0] lrd, input logic [31:0] ldat,
                      input bit ps, input logic [4:0] prd, output bit acc);
    bit ready, take, pop, byp, push;
    ent_t h;
    wr_t w;
    st_t s;
    ready = (m_q.size() < DEPTH);
    if (m_starve == STARVE_MAX) aw = 0;
    wb.alu_we_i = aw; wb.alu_rd_i = ard; wb.alu_data_i = adat;
    wb.lsu_valid_i = lv; wb.lsu_rd_i = lrd; wb.lsu_data_i = ldat;
    wb.pend_set_i = ps; wb.pend_rd_i = prd;
    take = aw && (ard != 0);
    byp = 0;
`ifdef WB_BYPASS_EN
    byp = !take && (m_q.size() == 0) && lv;
`endif
    pop  = !take && (m_q.size() > 0);
    push = lv && ready && !byp;
    acc  = push || byp;
    w.cyc = cyc + 1;
    if (take) begin
      w.rd = ard; w.data = adat; exp_wr.push_back(w);
    end else if (pop) begin
      h = m_q.pop_front();
      if (h.rd != 0) begin w.rd = h.rd; w.data = h.data; exp_wr.push_back(w); end
      m_busy[h.rd] = 1'b0;
    end else if (byp) begin
      if (lrd != 0) begin w.rd = lrd; w.data = ldat; exp_wr.push_back(w); end
      m_busy[lrd] = 1'b0;
    end
    if (ps && prd != 0) m_busy[prd] = 1'b1;
    if (pop) m_starve = 0;
    else if (m_q.size() > 0) m_starve++;
    if (push) begin h.rd = lrd; h.data = ldat; m_q.push_back(h); end
    s.cyc = cyc + 1; s.busy = m_busy; s.ready = (m_q.size() < DEPTH);
    s.stall = (m_starve == STARVE_MAX); s.chk_bus = 0;
    exp_st.push_back(s);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, acc);
  endtask

  task automatic do_reset(input int n);
    st_t s;
    rst = 1'b1;
    exp_wr.delete(); exp_st.delete(); m_q.delete(); launched.delete();
    m_busy = 32'd0; m_starve = 0; have_item = 0;
    drive_idle();
    for (int i = 0; i < n; i++) begin
      s.cyc = cyc; s.busy = 32'd0; s.ready = 1'b1; s.stall = 1'b0; s.chk_bus = 1;
      exp_st.push_back(s);
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  function automatic logic [4:0] pick_free();
    logic [4:0] r;
    for (int k = 0; k < 8; k++) begin
      r = 5'($urandom_range(1, 31));
      if (!m_busy[r]) return r;
    end
    return 5'd0;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc, aw, ps;
    logic [4:0] ard, prd;
    int idx, guard;
    drive_idle();
    @(posedge clk); #1;
    do_reset(3);

    // ALU write visible for exactly one cycle
    step(1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, acc);
    idle(2);

    // pending long-latency write to x7
    step(0, 0, 0, 0, 0, 0, 1, 7, acc);
    step(0, 0, 0, 1, 7, 32'd42, 0, 0, acc);
    idle(3);

    // x0 traffic from both producers
    step(1, 0, 32'h1111_1111, 1, 0, 32'h2222_2222, 0, 0, acc);
    step(1, 0, 32'h3333_3333, 0, 0, 0, 0, 0, acc);
    idle(3);

    // re-launch x9 on the edge its previous result retires
    step(0, 0, 0, 0, 0, 0, 1, 9, acc);
    step(0, 0, 0, 1, 9, 32'd99, 0, 0, acc);
    step(0, 0, 0, 0, 0, 0, 1, 9, acc);
    step(0, 0, 0, 1, 9, 32'd100, 0, 0, acc);
    idle(3);

    // fill under continuous ALU traffic until starvation forces drains
    for (int k = 0; k < 5; k++) step(1, 20, 32'(k), 0, 0, 0, 1, 5'(10 + k), acc);
    idx = 0;
    for (int k = 0; k < 24; k++) begin
      step(1, 5'(20 + (k % 2)), 32'(1000 + k), idx < 5, 5'(10 + idx), 32'(100 + idx), 0, 0, acc);
      if (acc) idx++;
    end
    idle(8);

    // reset mid-run with three buffered entries and x2/x5 pending
    step(1, 3, 32'hA, 0, 0, 0, 1, 2, acc);
    step(1, 3, 32'hB, 0, 0, 0, 1, 5, acc);
    step(1, 3, 32'hC, 1, 2, 32'h22, 0, 0, acc);
    step(1, 3, 32'hD, 1, 5, 32'h55, 0, 0, acc);
    step(1, 3, 32'hE, 1, 0, 32'h00, 0, 0, acc);
    do_reset(2);
    idle(6);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      aw  = ($urandom_range(0, 7) < ((i < 750) ? 7 : 3));
      ard = ($urandom_range(0, 9) == 0) ? 5'd0 : pick_free();
      if (!have_item) begin
        if (launched.size() > 0 && $urandom_range(0, 2) == 0) begin
          item.rd = launched.pop_front(); item.data = $urandom; have_item = 1;
        end else if ($urandom_range(0, 19) == 0) begin
          item.rd = 5'd0; item.data = $urandom; have_item = 1;
        end
      end
      ps  = ($urandom_range(0, 3) == 0);
      prd = pick_free();
      if (prd == 0) ps = 0;
      step(aw, ard, $urandom, have_item, item.rd, item.data, ps, prd, acc);
      if (acc) have_item = 0;
      if (ps) launched.push_back(prd);
    end

    // retire everything still outstanding
    guard = 0;
    while ((have_item || launched.size() > 0) && guard < 400) begin
      if (!have_item) begin
        item.rd = launched.pop_front(); item.data = $urandom; have_item = 1;
      end
      step(0, 0, 0, 1, item.rd, item.data, 0, 0, acc);
      if (acc) have_item = 0;
      guard++;
    end
    idle(DEPTH + 6);
    @(negedge clk); #1;
    chk("scoreboard_drained", exp_wr.size(), 32'd0);
    chk("final_busy", wb.busy_o, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
